approx_mul_sweep_bist: RTL and testbench

On-chip exhaustive-sweep evaluator for the approximate recursive multipliers. It generates every operand pair for an external multiplier instance, captures the returned product and compares it against the exact product. It accumulates match count, error count and, optionally, error-distance statistics. It is the hardware initiator/checker counterpart of the multiplier datapath, used for silicon and FPGA accuracy characterisation.

---
 rtl/approx_bist_pkg.sv | 23 ++
 rtl/bist_delay_line.sv | 42 ++++
 rtl/approx_mul_sweep_bist.sv | 185 ++++++++++++++++++
 tb/tb_approx_mul_sweep_bist.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_bist_pkg.sv
// Shared types and width helpers for the approximate-multiplier sweep BIST.
package approx_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned prod_w(input int unsigned width);
    return 2 * width;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic int unsigned sum_w(input int unsigned width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Fixed-latency pipe aligning {valid, exact product} with the external multiplier output.
module bist_delay_line #(
  parameter int unsigned DEPTH  = 0,
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign dout       = din;
    end else begin : g_pipe
      logic [DATA_W-1:0] pipe_q [DEPTH];
      logic [DATA_W-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign dout = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/approx_mul_sweep_bist.sv
// Exhaustive operand sweep and product checker for an external multiplier.
// Define APPROX_BIST_ERR_STATS_EN to build the sum_ed/max_ed error-distance accumulators.
module approx_mul_sweep_bist
  import approx_bist_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  input  logic [2*WIDTH-1:0]   prod_in,
  output logic [2*WIDTH:0]     correct_cnt,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [4*WIDTH-1:0]   sum_ed,
  output logic [2*WIDTH-1:0]   max_ed
);

  localparam int unsigned PROD_W  = prod_w(WIDTH);
  localparam int unsigned CNT_W   = cnt_w(WIDTH);
  localparam int unsigned SUM_W   = sum_w(WIDTH);
  localparam logic [15:0] DRAIN_LAST = (MUL_LAT > 0) ? 16'(MUL_LAT - 1) : '0;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        drain_q, drain_d;
  logic [CNT_W-1:0]   correct_q, correct_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic [PROD_W-1:0]  exact;
  logic               dly_valid;
  logic [PROD_W-1:0]  dly_exact;
  logic               start_sweep;

  assign exact       = PROD_W'(op_a_q) * PROD_W'(op_b_q);
  assign start_sweep = (state_q == ST_IDLE) && start;

  bist_delay_line #(
    .DEPTH  (MUL_LAT),
    .DATA_W (PROD_W + 1)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({op_valid_q, exact}),
    .dout  ({dly_valid, dly_exact})
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = 1'b0;
    drain_d    = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SWEEP;
          op_a_d     = '0;
          op_b_d     = '0;
          op_valid_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (&{op_a_q, op_b_q}) begin
          drain_d = '0;
          state_d = (MUL_LAT > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          op_valid_d = 1'b1;
          op_b_d     = op_b_q + 1'b1;
          if (&op_b_q) begin
            op_a_d = op_a_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    correct_d = correct_q;
    err_d     = err_q;
    if (start_sweep) begin
      correct_d = '0;
      err_d     = '0;
    end else if (dly_valid) begin
      if (prod_in == dly_exact) begin
        correct_d = correct_q + 1'b1;
      end else begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= '0;
      correct_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      correct_q  <= correct_d;
      err_q      <= err_d;
    end
  end

`ifdef APPROX_BIST_ERR_STATS_EN
  logic [PROD_W-1:0] ed;
  logic [SUM_W:0]    sum_ext;
  logic [SUM_W-1:0]  sum_ed_q, sum_ed_d;
  logic [PROD_W-1:0] max_ed_q, max_ed_d;

  // Unsigned magnitude of the difference; the wider sum carry drives saturation.
  always_comb begin
    ed       = (prod_in >= dly_exact) ? (prod_in - dly_exact) : (dly_exact - prod_in);
    sum_ext  = {1'b0, sum_ed_q} + (SUM_W + 1)'(ed);
    sum_ed_d = sum_ed_q;
    max_ed_d = max_ed_q;
    if (start_sweep) begin
      sum_ed_d = '0;
      max_ed_d = '0;
    end else if (dly_valid) begin
      sum_ed_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (ed > max_ed_q) begin
        max_ed_d = ed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_ed_q <= '0;
      max_ed_q <= '0;
    end else begin
      sum_ed_q <= sum_ed_d;
      max_ed_q <= max_ed_d;
    end
  end

  assign sum_ed = sum_ed_q;
  assign max_ed = max_ed_q;
`else
  assign sum_ed = '0;
  assign max_ed = '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_valid    = op_valid_q;
  assign correct_cnt = correct_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_approx_mul_sweep_bist.sv
// Directed bench: WIDTH=4 sweeps (exact/zero/xor, mid-sweep reset), WIDTH=4 MUL_LAT=2, one WIDTH=8 sweep.
module tb_approx_mul_sweep_bist;

`ifdef APPROX_BIST_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8, MUL_LAT=0, exact combinational multiplier
  logic        rst8, start8, busy8, done8, v8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [16:0] cc8, ec8;
  logic [31:0] se8;
  logic [15:0] me8;
  assign prod8 = {8'b0, a8} * {8'b0, b8};

  // WIDTH=4, MUL_LAT=0, selectable faulty multiplier
  logic        rst4, start4, busy4, done4, v4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4, ex4;
  logic [8:0]  cc4, ec4;
  logic [15:0] se4;
  logic [7:0]  me4;
  logic [1:0]  mode4;
  assign ex4 = {4'b0, a4} * {4'b0, b4};
  always_comb begin
    prod4 = ex4;
    if (mode4 == 2'd1) prod4 = 8'd0;
    else if (mode4 == 2'd2) prod4 = ex4 ^ 8'd1;
  end

  // WIDTH=4, MUL_LAT=2, exact multiplier with two register stages
  logic        rstl, startl, busyl, donel, vl;
  logic [3:0]  al, bl;
  logic [7:0]  p1, p2;
  logic [8:0]  ccl, ecl;
  logic [15:0] sel;
  logic [7:0]  mel;
  always @(posedge clk) begin
    p1 <= {4'b0, al} * {4'b0, bl};
    p2 <= p1;
  end

  approx_mul_sweep_bist #(.WIDTH(8), .MUL_LAT(0)) dut8 (
    .clk(clk), .rst_n(rst8), .start(start8), .busy(busy8), .done(done8),
    .op_a(a8), .op_b(b8), .op_valid(v8), .prod_in(prod8),
    .correct_cnt(cc8), .err_cnt(ec8), .sum_ed(se8), .max_ed(me8));

  approx_mul_sweep_bist #(.WIDTH(4), .MUL_LAT(0)) dut4 (
    .clk(clk), .rst_n(rst4), .start(start4), .busy(busy4), .done(done4),
    .op_a(a4), .op_b(b4), .op_valid(v4), .prod_in(prod4),
    .correct_cnt(cc4), .err_cnt(ec4), .sum_ed(se4), .max_ed(me4));

  approx_mul_sweep_bist #(.WIDTH(4), .MUL_LAT(2)) dutl (
    .clk(clk), .rst_n(rstl), .start(startl), .busy(busyl), .done(donel),
    .op_a(al), .op_b(bl), .op_valid(vl), .prod_in(p2),
    .correct_cnt(ccl), .err_cnt(ecl), .sum_ed(sel), .max_ed(mel));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run4(input logic [1:0] mode, input int exp_c, input int exp_e,
                      input int exp_max, input int exp_sum, input string tag);
    int cyc, busyc, validc;
    mode4  = mode;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check({tag, "_c1_busy"}, 64'(busy4), 64'd1);
    check({tag, "_c1_valid"}, 64'(v4), 64'd1);
    check({tag, "_c1_ab"}, 64'({a4, b4}), 64'd0);
    cyc = 1; busyc = 0; validc = 0;
    while (done4 !== 1'b1 && cyc < 400) begin
      if (busy4) busyc++;
      if (v4) validc++;
      tick();
      cyc++;
    end
    if (busy4) busyc++;
    check({tag, "_done_cyc"}, 64'(cyc), 64'd257);
    check({tag, "_busy_cyc"}, 64'(busyc), 64'd257);
    check({tag, "_valid_cyc"}, 64'(validc), 64'd256);
    check({tag, "_correct"}, 64'(cc4), 64'(exp_c));
    check({tag, "_err"}, 64'(ec4), 64'(exp_e));
    check({tag, "_max_ed"}, 64'(me4), STATS ? 64'(exp_max) : 64'd0);
    check({tag, "_sum_ed"}, 64'(se4), STATS ? 64'(exp_sum) : 64'd0);
    tick();
    tick();
    check({tag, "_idle_done"}, 64'(done4), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy4), 64'd0);
    check({tag, "_hold_cnt"}, 64'(cc4 + ec4), 64'd256);
    check({tag, "_hold_ab"}, 64'({a4, b4}), 64'hFF);
  endtask

  initial begin
    int cyc, busyc, validc;
    rst8 = 1'b0; rst4 = 1'b0; rstl = 1'b0;
    start8 = 1'b0; start4 = 1'b0; startl = 1'b0;
    mode4 = 2'd0;
    tick();
    tick();
    check("rst_busy", 64'({busy8, busy4, busyl}), 64'd0);
    check("rst_done", 64'({done8, done4, donel}), 64'd0);
    check("rst_valid", 64'({v8, v4, vl}), 64'd0);
    check("rst_ab8", 64'({a8, b8}), 64'd0);
    check("rst_cnt8", 64'({cc8, ec8}), 64'd0);
    check("rst_stats8", 64'({se8, me8}), 64'd0);
    rst8 = 1'b1; rst4 = 1'b1; rstl = 1'b1;
    tick();

    run4(2'd0, 256, 0, 0, 0, "w4_exact");
    run4(2'd1, 31, 225, 225, 14400, "w4_zero");
    run4(2'd2, 0, 256, 1, 256, "w4_xor1");

    // Reset at cycle 100 of a sweep, then a clean rerun
    mode4  = 2'd0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    check("mid_ab", 64'({a4, b4}), 64'h63);
    check("mid_correct", 64'(cc4), 64'd99);
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    check("mrst_busy", 64'(busy4), 64'd0);
    check("mrst_done", 64'(done4), 64'd0);
    check("mrst_valid", 64'(v4), 64'd0);
    check("mrst_ab", 64'({a4, b4}), 64'd0);
    check("mrst_cnt", 64'({cc4, ec4}), 64'd0);
    check("mrst_stats", 64'({se4, me4}), 64'd0);
    tick();
    check("mrst_stay_idle", 64'(busy4), 64'd0);
    run4(2'd0, 256, 0, 0, 0, "w4_rerun");

    // MUL_LAT=2 with a two-stage registered multiplier
    startl = 1'b1;
    tick();
    startl = 1'b0;
    cyc = 1; busyc = 0; validc = 0;
    while (donel !== 1'b1 && cyc < 400) begin
      if (busyl) busyc++;
      if (vl) validc++;
      tick();
      cyc++;
    end
    if (busyl) busyc++;
    check("lat2_done_cyc", 64'(cyc), 64'd259);
    check("lat2_busy_cyc", 64'(busyc), 64'd259);
    check("lat2_valid_cyc", 64'(validc), 64'd256);
    check("lat2_correct", 64'(ccl), 64'd256);
    check("lat2_err", 64'(ecl), 64'd0);
    tick();
    check("lat2_idle_done", 64'({donel, busyl}), 64'd0);

    // Full WIDTH=8 sweep with start re-pulsed at cycles 5 and 40000
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 1; busyc = 0; validc = 0;
    while (done8 !== 1'b1 && cyc < 70000) begin
      if (busy8) busyc++;
      if (v8) validc++;
      if (cyc == 300) check("w8_c300_ab", 64'({a8, b8}), 64'h012B);
      start8 = (cyc == 5 || cyc == 40000);
      tick();
      cyc++;
    end
    start8 = 1'b0;
    if (busy8) busyc++;
    check("w8_done_cyc", 64'(cyc), 64'd65537);
    check("w8_busy_cyc", 64'(busyc), 64'd65537);
    check("w8_valid_cyc", 64'(validc), 64'd65536);
    check("w8_correct", 64'(cc8), 64'd65536);
    check("w8_err", 64'(ec8), 64'd0);
    check("w8_stats", 64'({se8, me8}), 64'd0);
    tick();
    check("w8_idle", 64'({done8, busy8, v8}), 64'd0);
    check("w8_hold_ab", 64'({a8, b8}), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
